// File: rtl/setpt_pwm_if.sv
// Setpoint-in / bridge-drive-out bundle for the setpoint PWM driver.
interface setpt_pwm_if;
  logic       en;
  logic [7:0] setpt;
  logic       pwm;
  logic       in1;
  logic       in2;
  logic       dir_cur;
  logic [6:0] duty_cur;
  logic       busy;

  modport master (
    output en, setpt,
    input  pwm, in1, in2, dir_cur, duty_cur, busy
  );

  modport slave (
    input  en, setpt,
    output pwm, in1, in2, dir_cur, duty_cur, busy
  );
endinterface

// File: rtl/setpt_pwm_driver.sv
// H-bridge PWM driver: ramps duty toward a signed setpoint once per PWM period
// and inserts a bridge-off dead time whenever the direction reverses.
module setpt_pwm_driver #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned RAMP_STEP    = 1,
  parameter int unsigned DEAD_PERIODS = 2
) (
  input  logic        clk,
  input  logic        rst,
  setpt_pwm_if.slave  bus
);

  localparam int unsigned PW = 8;
  localparam int unsigned DW = 7;
  localparam int unsigned CW = 4;
  localparam logic [DW-1:0] PCNT_MAX = 7'd126;

  typedef enum logic [1:0] {IDLE, DRIVE, DEAD} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   presc, presc_n;
  logic [DW-1:0]   pcnt, pcnt_n;
  logic            tick, pb;
  logic [7:0]      target, target_n;
  logic [DW-1:0]   duty, duty_n;
  logic            dir, dir_n;
  logic [CW-1:0]   dead_cnt, dead_n;
  logic            pwm_q, in1_q, in2_q, busy_q;
  logic            pwm_n, in1_n, in2_n, busy_n, drive_n;
  logic            tgt_dir;
  logic [DW-1:0]   tgt_mag, eff, ramp;
  logic [7:0]      d8, e8, diff, step8;

  // Free-running prescaler and PWM period counter; pb marks the pcnt wrap.
  always_comb begin
    tick    = (presc == PW'(CLK_DIV - 1));
    presc_n = tick ? '0 : presc + 8'd1;
    pb      = tick && (pcnt == PCNT_MAX);
    pcnt_n  = pcnt;
    if (tick) pcnt_n = (pcnt == PCNT_MAX) ? '0 : pcnt + 7'd1;
  end

  // Target capture and one bounded ramp step toward the effective target.
  always_comb begin
    target_n = pb ? bus.setpt : target;
    tgt_dir  = target_n[7];
    tgt_mag  = target_n[6:0];
    // A reversed request ramps down to zero first; magnitude 0 is a plain stop.
    eff      = ((tgt_dir == dir) || (tgt_mag == 7'd0)) ? tgt_mag : 7'd0;
    d8       = {1'b0, duty};
    e8       = {1'b0, eff};
    diff     = (e8 >= d8) ? (e8 - d8) : (d8 - e8);
    step8    = (diff < 8'(RAMP_STEP)) ? diff : 8'(RAMP_STEP);
    ramp     = (e8 >= d8) ? DW'(d8 + step8) : DW'(d8 - step8);
  end

  // Next-state and next-output logic; en=0 overrides everything.
  always_comb begin
    state_n = state;
    duty_n  = duty;
    dir_n   = dir;
    dead_n  = dead_cnt;
    if (!bus.en) begin
      state_n = IDLE;
      duty_n  = '0;
      dead_n  = '0;
    end else begin
      case (state)
        IDLE: state_n = DRIVE;
        DRIVE: begin
          if (pb) begin
            if ((duty == 7'd0) && (tgt_dir != dir) && (tgt_mag != 7'd0)) begin
              state_n = DEAD;
              dead_n  = '0;
            end else begin
              duty_n = ramp;
            end
          end
        end
        DEAD: begin
          if (pb) begin
            if (dead_cnt == CW'(DEAD_PERIODS - 1)) begin
              state_n = DRIVE;
              dir_n   = tgt_dir;
              dead_n  = '0;
            end else begin
              dead_n = dead_cnt + 4'd1;
            end
          end
        end
        default: begin
          state_n = IDLE;
          duty_n  = '0;
          dead_n  = '0;
        end
      endcase
    end
    drive_n = (state_n == DRIVE);
    pwm_n   = drive_n && (pcnt_n < duty_n);
    in1_n   = drive_n && (duty_n != 7'd0) && !dir_n;
    in2_n   = drive_n && (duty_n != 7'd0) && dir_n;
    busy_n  = (state_n == DEAD);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      presc    <= '0;
      pcnt     <= '0;
      target   <= '0;
      duty     <= '0;
      dir      <= 1'b0;
      dead_cnt <= '0;
      pwm_q    <= 1'b0;
      in1_q    <= 1'b0;
      in2_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      presc    <= presc_n;
      pcnt     <= pcnt_n;
      target   <= target_n;
      duty     <= duty_n;
      dir      <= dir_n;
      dead_cnt <= dead_n;
      pwm_q    <= pwm_n;
      in1_q    <= in1_n;
      in2_q    <= in2_n;
      busy_q   <= busy_n;
    end
  end

  assign bus.pwm      = pwm_q;
  assign bus.in1      = in1_q;
  assign bus.in2      = in2_q;
  assign bus.busy     = busy_q;
  assign bus.duty_cur = duty;
  assign bus.dir_cur  = dir;

endmodule

// File: tb/tb_setpt_pwm_driver.sv
// Bench for setpt_pwm_driver: period-boundary vectors checked through a scoreboard.
module tb_setpt_pwm_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  setpt_pwm_if bus1 ();
  setpt_pwm_if bus2 ();

  setpt_pwm_driver #(.CLK_DIV(1), .RAMP_STEP(1), .DEAD_PERIODS(2)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  setpt_pwm_driver #(.CLK_DIV(1), .RAMP_STEP(50), .DEAD_PERIODS(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:0] setpt;
    logic [6:0] duty;
    logic       dir;
    logic       busy;
    logic       in1;
    logic       in2;
  } vec_t;

  typedef struct {
    string      name;
    logic [6:0] duty;
    logic       dir;
    logic       busy;
    logic       in1;
    logic       in2;
    logic       pwm;
  } exp_t;

  vec_t vecs[21];
  exp_t sb[$];

  function automatic vec_t mkv(input logic [7:0] sp, input int d, input logic dr,
                               input logic b, input logic i1, input logic i2);
    vec_t v;
    v.en = 1'b1; v.setpt = sp; v.duty = 7'(d); v.dir = dr; v.busy = b;
    v.in1 = i1; v.in2 = i2;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // After the pb edge pcnt is 0, so pwm is high exactly when driving a nonzero duty.
  task automatic push(input string nm, input int d, input logic dr, input logic b,
                      input logic i1, input logic i2);
    exp_t e;
    e.name = nm; e.duty = 7'(d); e.dir = dr; e.busy = b; e.in1 = i1; e.in2 = i2;
    e.pwm = (d != 0) && !b;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({e.name, "_duty"}, int'(bus1.duty_cur), int'(e.duty));
    chk({e.name, "_dir"},  int'(bus1.dir_cur),  int'(e.dir));
    chk({e.name, "_busy"}, int'(bus1.busy),     int'(e.busy));
    chk({e.name, "_in1"},  int'(bus1.in1),      int'(e.in1));
    chk({e.name, "_in2"},  int'(bus1.in2),      int'(e.in2));
    chk({e.name, "_pwm"},  int'(bus1.pwm),      int'(e.pwm));
  endtask

  task automatic clk_n(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
  endtask

  // Period boundaries fall on every 127th edge after reset release (CLK_DIV=1).
  task automatic to_pb(input int n);
    int k;
    k = 127 - (cyc % 127) + 127 * (n - 1);
    clk_n(k);
  endtask

  initial begin
    int p1, p2, i1c, d2;

    vecs[0]  = mkv(8'h03, 4, 0, 0, 1, 0);
    vecs[1]  = mkv(8'h03, 3, 0, 0, 1, 0);
    vecs[2]  = mkv(8'h83, 2, 0, 0, 1, 0);
    vecs[3]  = mkv(8'h83, 1, 0, 0, 1, 0);
    vecs[4]  = mkv(8'h83, 0, 0, 0, 0, 0);
    vecs[5]  = mkv(8'h83, 0, 0, 1, 0, 0);
    vecs[6]  = mkv(8'h83, 0, 0, 1, 0, 0);
    vecs[7]  = mkv(8'h83, 0, 1, 0, 0, 0);
    vecs[8]  = mkv(8'h83, 1, 1, 0, 0, 1);
    vecs[9]  = mkv(8'h83, 2, 1, 0, 0, 1);
    vecs[10] = mkv(8'h83, 3, 1, 0, 0, 1);
    vecs[11] = mkv(8'h80, 2, 1, 0, 0, 1);
    vecs[12] = mkv(8'h00, 1, 1, 0, 0, 1);
    vecs[13] = mkv(8'h00, 0, 1, 0, 0, 0);
    vecs[14] = mkv(8'h00, 0, 1, 0, 0, 0);
    vecs[15] = mkv(8'h81, 1, 1, 0, 0, 1);
    vecs[16] = mkv(8'h01, 0, 1, 0, 0, 0);
    vecs[17] = mkv(8'h01, 0, 1, 1, 0, 0);
    vecs[18] = mkv(8'h81, 0, 1, 1, 0, 0);
    vecs[19] = mkv(8'h81, 0, 1, 0, 0, 0);
    vecs[20] = mkv(8'h81, 1, 1, 0, 0, 1);

    bus1.en = 1'b0; bus1.setpt = 8'h00;
    bus2.en = 1'b0; bus2.setpt = 8'h00;

    // Reset values
    #1;
    chk("rst_pwm",  int'(bus1.pwm), 0);
    chk("rst_in1",  int'(bus1.in1), 0);
    chk("rst_in2",  int'(bus1.in2), 0);
    chk("rst_busy", int'(bus1.busy), 0);
    chk("rst_duty", int'(bus1.duty_cur), 0);
    chk("rst_dir",  int'(bus1.dir_cur), 0);

    @(negedge clk);
    rst = 1'b0; cyc = 0;
    bus1.en = 1'b1; bus1.setpt = 8'h05;
    bus2.en = 1'b1; bus2.setpt = 8'h7F;
    clk_n(1);
    chk("drive_entry_duty", int'(bus1.duty_cur), 0);
    chk("drive_entry_in1",  int'(bus1.in1), 0);
    chk("drive_entry_busy", int'(bus1.busy), 0);

    // Ramp up by one per period; second unit ramps by 50 and saturates at 127
    for (int i = 1; i <= 5; i++) begin
      push($sformatf("ramp%0d", i), i, 0, 0, 1, 0);
      to_pb(1);
      pop_cmp();
      d2 = (50 * i > 127) ? 127 : 50 * i;
      chk($sformatf("big_step_pb%0d", i), int'(bus2.duty_cur), d2);
    end

    // One full period at duty 5; setpt wiggles mid-period must not matter
    p1 = 0; p2 = 0; i1c = 0;
    for (int i = 0; i < 127; i++) begin
      p1 += int'(bus1.pwm);
      p2 += int'(bus2.pwm);
      i1c += int'(bus1.in1 && !bus1.in2);
      if (i == 40) bus1.setpt = 8'h20;
      if (i == 80) bus1.setpt = 8'h05;
      clk_n(1);
    end
    chk("pwm_high_count_d5",   p1, 5);
    chk("pwm_high_count_d127", p2, 127);
    chk("in1_fwd_count",       i1c, 127);
    push("midperiod_toggle", 5, 0, 0, 1, 0);
    pop_cmp();

    // Table: down-ramp, reversal with dead time, stops, return-during-dead
    foreach (vecs[i]) begin
      bus1.en = vecs[i].en;
      bus1.setpt = vecs[i].setpt;
      push($sformatf("row%0d", i), int'(vecs[i].duty), vecs[i].dir, vecs[i].busy,
           vecs[i].in1, vecs[i].in2);
      to_pb(1);
      pop_cmp();
    end

    // Reverse ramp up to 10
    bus1.setpt = 8'h8A;
    for (int i = 2; i <= 10; i++) begin
      push($sformatf("rev_ramp%0d", i), i, 1, 0, 0, 1);
      to_pb(1);
      pop_cmp();
    end

    // One-clock en drop at duty 10 clears duty and outputs, keeps direction
    bus1.en = 1'b0;
    clk_n(1);
    chk("endrop_pwm",  int'(bus1.pwm), 0);
    chk("endrop_in1",  int'(bus1.in1), 0);
    chk("endrop_in2",  int'(bus1.in2), 0);
    chk("endrop_duty", int'(bus1.duty_cur), 0);
    chk("endrop_dir",  int'(bus1.dir_cur), 1);
    bus1.en = 1'b1;
    clk_n(1);
    chk("reenable_duty", int'(bus1.duty_cur), 0);
    push("reenable_pb", 1, 1, 0, 0, 1);
    to_pb(1);
    pop_cmp();

    // Drive into dead time, then assert reset asynchronously mid-period
    bus1.setpt = 8'h0A;
    push("to_zero", 0, 1, 0, 0, 0);
    to_pb(1);
    pop_cmp();
    push("into_dead", 0, 1, 1, 0, 0);
    to_pb(1);
    pop_cmp();
    clk_n(30);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", int'(bus1.busy), 0);
    chk("async_rst_pwm",  int'(bus1.pwm), 0);
    chk("async_rst_in",   int'(bus1.in1 | bus1.in2), 0);
    chk("async_rst_dir",  int'(bus1.dir_cur), 0);
    chk("async_rst_duty", int'(bus1.duty_cur), 0);
    @(negedge clk);
    rst = 1'b0; cyc = 0;
    bus1.setpt = 8'h05;
    clk_n(1);
    chk("post_rst_busy", int'(bus1.busy), 0);
    chk("post_rst_duty", int'(bus1.duty_cur), 0);
    push("post_rst_pb1", 1, 0, 0, 1, 0);
    to_pb(1);
    pop_cmp();

    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/setpt_pwm_driver.md
SETPT_PWM_DRIVER -- requirements
Module: setpt_pwm_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per PWM count, legal range 1..255.
REQ-002 SHALL have parameter RAMP_STEP, default 1: maximum duty change per PWM period, legal range 1..127.
REQ-003 SHALL have parameter DEAD_PERIODS, default 2: full PWM periods with the bridge off during a reversal, legal range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port en, input, 1 bit: drive enable; 0 means coast.
REQ-007 SHALL have port setpt, input, 8 bits: bit7 is direction (0 fwd, 1 rev); bits6:0 are magnitude 0..127.
REQ-008 SHALL have port pwm, output, 1 bit: PWM to the H-bridge enable pin.
REQ-009 SHALL have port in1, output, 1 bit: bridge input 1.
REQ-010 SHALL have port in2, output, 1 bit: bridge input 2.
REQ-011 SHALL have port dir_cur, output, 1 bit: direction currently applied.
REQ-012 SHALL have port duty_cur, output, 7 bits: magnitude currently applied.
REQ-013 SHALL have port busy, output, 1 bit: 1 while in state DEAD.

Function
REQ-014 SHALL run a prescaler counting 0..CLK_DIV-1 and assert an internal tick for one clk when the count equals CLK_DIV-1; the prescaler SHALL run freely regardless of en.
REQ-015 SHALL run a PWM counter pcnt, 0..126, advancing on tick and wrapping from 126 to 0; a period boundary (pb) is the tick on which pcnt wraps, so a period is 127*CLK_DIV clk.
REQ-016 SHALL sample setpt into a target register only at pb; setpt changes mid-period SHALL have no effect until the next pb.
REQ-017 SHALL implement states IDLE, DRIVE and DEAD.
REQ-018 In IDLE, pwm, in1 and in2 SHALL be 0 and duty_cur SHALL be 0; the block SHALL go to DRIVE on the first clk with en=1.
REQ-019 In any state, en=0 SHALL move the block to IDLE on the next clk, with duty_cur cleared and outputs off; dir_cur SHALL be held.
REQ-020 In DRIVE, pwm SHALL equal (state==DRIVE) && (pcnt < duty_cur), registered; duty 0 gives a constant 0 and duty 127 gives a constant 1.
REQ-021 In DRIVE with duty_cur>0, in1/in2 SHALL be 1/0 when dir_cur=0 and 0/1 when dir_cur=1; with duty_cur=0, both SHALL be 0.
REQ-022 At each pb in DRIVE, duty_cur SHALL move toward the effective target by min(RAMP_STEP, |difference|), using 8-bit intermediate arithmetic; it SHALL never overshoot, and no 7-bit wrap is permitted.
REQ-023 Effective target SHALL equal the target magnitude when the target direction equals dir_cur or the target magnitude is 0; otherwise it SHALL be 0.
REQ-024 A magnitude of 0 with any direction bit (0x00, 0x80) SHALL be treated as stop: ramp to 0, with no reversal and no change to dir_cur.
REQ-025 At a pb in DRIVE where duty_cur==0 at entry and the target direction differs from dir_cur with nonzero target magnitude, the block SHALL go to DEAD.
REQ-026 DEAD SHALL hold pwm, in1 and in2 at 0 and busy at 1, and count DEAD_PERIODS pbs.
REQ-027 On the final counted pb, DEAD SHALL load dir_cur from the target direction and return to DRIVE; ramp-up SHALL begin at the following pb.
REQ-028 A target that returns to the original direction during DEAD SHALL NOT abort DEAD: the dead time completes and dir_cur takes the target direction sampled at the final pb.
REQ-029 At most one duty step SHALL occur per pb, and pwm and in1/in2 SHALL never be simultaneously active with in1=in2=1.

Reset
REQ-030 While rst is high: state=IDLE, prescaler=0, pcnt=0, target=0x00, duty_cur=0, dir_cur=0, pwm=0, in1=0, in2=0, busy=0, dead counter=0.
REQ-031 Release of rst mid-ramp or mid-DEAD SHALL restart from the REQ-030 values with no carry-over.

Verification (CLK_DIV=1, RAMP_STEP=1, DEAD_PERIODS=2 unless stated)
REQ-032 en=1, setpt=0x05 from reset -> duty_cur increments 1 per pb and reaches 5 at the 5th pb; then pwm is high 5 of every 127 clk; in1=1, in2=0.
REQ-033 Steady at 0x03, then setpt=0x83 -> duty ramps 3,2,1,0 over 3 pbs; busy=1 for 2 periods; dir_cur=1; in2=1; duty climbs back to 3 over 3 pbs.
REQ-034 setpt=0x7F with RAMP_STEP=50 -> duty sequence 50, 100, 127; pwm constant 1 at 127, with no overshoot or wrap.
REQ-035 At duty 10, drop en for 1 clk -> next clk pwm=in1=in2=0 and duty_cur=0; on en=1, ramp restarts from 0.
REQ-036 setpt toggled 0x05 -> 0x20 -> 0x05 within one period -> only the value present at pb is used.
REQ-037 Assert rst during DEAD -> all outputs 0 immediately (asynchronous); after release the block returns to IDLE/DRIVE per REQ-018, with busy=0.
